// File: rtl/spi_slave_sync.sv
// Fully synchronous SPI slave: CS/SCK/MOSI are oversampled in the CLK domain,
// all four SPI modes, configurable word width and bit order, back-to-back words.
`timescale 1ns/1ps

module spi_slave_sync #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] DOUT,
  output logic             DOUT_ACK,
  output logic [WIDTH-1:0] DIN,
  output logic             DIN_VALID,
  output logic             BUSY,
  output logic             ABORT
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam int              TX_POS   = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           r_state;
  logic [2:0]       r_cs_sync;
  logic [2:0]       r_sck_sync;
  logic [1:0]       r_mosi_sync;
  logic [WIDTH-1:0] r_tx;
  logic             r_tx_en;
  logic             r_next_pend;
  logic             r_word_start;
  logic [WIDTH-1:0] r_rx;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [WIDTH-1:0] r_din;
  logic             r_din_valid;
  logic             r_busy;
  logic             r_abort;

  logic             w_cs_fall;
  logic             w_cs_rise;
  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_lead;
  logic             w_trail;
  logic             w_sample;
  logic             w_shift;
  logic             w_mosi;
  logic [WIDTH-1:0] w_rx_next;
  logic [WIDTH-1:0] w_tx_adv;
  logic             w_load;

  // Stage [1] is the synchronised level, stage [2] the copy used for edge detection.
  assign w_cs_fall  = ~r_cs_sync[1]  &  r_cs_sync[2];
  assign w_cs_rise  =  r_cs_sync[1]  & ~r_cs_sync[2];
  assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
  assign w_lead     = (CPOL != 0) ? w_sck_fall : w_sck_rise;
  assign w_trail    = (CPOL != 0) ? w_sck_rise : w_sck_fall;
  assign w_sample   = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift    = (CPHA != 0) ? w_lead  : w_trail;
  assign w_mosi     = r_mosi_sync[1];

  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx[WIDTH-2:0], w_mosi} : {w_mosi, r_rx[WIDTH-1:1]};
  assign w_tx_adv  = (MSB_FIRST != 0) ? (r_tx << 1) : (r_tx >> 1);

  // DOUT is captured when a word actually starts, so a frame that ends on a word
  // boundary never consumes a word it will not send. Until then (CPHA=0) the
  // first bit of the next word is previewed straight from DOUT.
  always_comb begin
    // NOTE: default first so no path leaves w_load unassigned (no latch).
    w_load = 1'b0;
    if (r_state == S_IDLE) begin
      w_load = w_cs_fall;
    end else if (!w_cs_rise && r_next_pend) begin
      w_load = (CPHA != 0) ? w_shift : w_sample;
    end
  end

  assign DOUT_ACK  = w_load;
  assign MISO      = r_tx_en & ((CPHA == 0 && r_next_pend) ? DOUT[TX_POS] : r_tx[TX_POS]);
  assign DIN       = r_din;
  assign DIN_VALID = r_din_valid;
  assign BUSY      = r_busy;
  assign ABORT     = r_abort;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_cs_sync    <= '0;
      r_sck_sync   <= '0;
      r_mosi_sync  <= '0;
      r_tx         <= '0;
      r_tx_en      <= 1'b0;
      r_next_pend  <= 1'b0;
      r_word_start <= 1'b0;
      r_rx         <= '0;
      r_rx_cnt     <= '0;
      r_din        <= '0;
      r_din_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      r_cs_sync   <= {r_cs_sync[1:0], CS};
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_din_valid <= 1'b0;
      r_abort     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state      <= S_ACTIVE;
            r_busy       <= 1'b1;
            r_tx         <= DOUT;
            r_tx_en      <= (CPHA == 0);
            r_word_start <= (CPHA != 0);
            r_next_pend  <= 1'b0;
            r_rx_cnt     <= '0;
          end
        end

        S_ACTIVE: begin
          if (w_cs_rise) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_tx_en      <= 1'b0;
            r_next_pend  <= 1'b0;
            r_word_start <= 1'b0;
            r_rx_cnt     <= '0;
            r_abort      <= (r_rx_cnt != '0);
          end else begin
            if (w_sample) begin
              r_rx <= w_rx_next;
              if (r_rx_cnt == LAST_BIT) begin
                r_rx_cnt    <= '0;
                r_din       <= w_rx_next;
                r_din_valid <= 1'b1;
                if (CPHA != 0) begin
                  r_next_pend  <= 1'b1;
                  r_word_start <= 1'b1;
                end
              end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
              end
              if (CPHA == 0 && r_next_pend) begin
                r_tx        <= DOUT;
                r_next_pend <= 1'b0;
              end
            end

            if (w_shift) begin
              if (CPHA == 0) begin
                if (r_rx_cnt == '0) r_next_pend <= 1'b1;
                else                r_tx        <= w_tx_adv;
              end else if (r_word_start) begin
                if (r_next_pend) r_tx <= DOUT;
                r_tx_en      <= 1'b1;
                r_word_start <= 1'b0;
                r_next_pend  <= 1'b0;
              end else begin
                r_tx <= w_tx_adv;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: one 8-bit LSB-first mode-0 instance plus
// four 16-bit MSB-first instances covering every CPOL/CPHA combination.
`timescale 1ns/1ps

module tb_spi_slave_sync;

  localparam int N    = 5;
  localparam int HALF = 50;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [N-1:0]  cs;
  logic [N-1:0]  sck;
  logic          mosi;
  logic [7:0]    dout8;
  logic [15:0]   dout16;
  wire  [N-1:0]  miso, ack, vld, busy, abrt;
  wire  [7:0]    din8;
  wire  [15:0]   din16 [4];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   exp_q [N][$];
  logic [7:0]    dout8_next [$];
  int            ack_cnt [N];
  int            vld_cnt [N];
  int            abt_cnt [N];

  always #5 CLK = ~CLK;

  spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .CS(cs[0]), .SCK(sck[0]), .MOSI(mosi), .MISO(miso[0]),
    .DOUT(dout8), .DOUT_ACK(ack[0]), .DIN(din8), .DIN_VALID(vld[0]), .BUSY(busy[0]),
    .ABORT(abrt[0])
  );

  for (genvar k = 0; k < 4; k++) begin : g_m16
    spi_slave_sync #(.WIDTH(16), .CPOL(k / 2), .CPHA(k % 2), .MSB_FIRST(1)) u_dut16 (
      .CLK(CLK), .RST_N(RST_N), .CS(cs[k+1]), .SCK(sck[k+1]), .MOSI(mosi), .MISO(miso[k+1]),
      .DOUT(dout16), .DOUT_ACK(ack[k+1]), .DIN(din16[k]), .DIN_VALID(vld[k+1]),
      .BUSY(busy[k+1]), .ABORT(abrt[k+1])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] din_of(input int k);
    if (k == 0) return {24'h0, din8};
    return {16'h0, din16[k-1]};
  endfunction

  // Monitor: counts strobes and compares DIN against the scoreboard on every DIN_VALID.
  initial begin
    for (int k = 0; k < N; k++) begin
      ack_cnt[k] = 0; vld_cnt[k] = 0; abt_cnt[k] = 0;
    end
    forever begin
      @(negedge CLK);
      for (int k = 0; k < N; k++) begin
        if (ack[k])  ack_cnt[k]++;
        if (abrt[k]) abt_cnt[k]++;
        if (vld[k]) begin
          vld_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL din_unexpected inst%0d: got %h, required no DIN_VALID", k, din_of(k));
          end else begin
            check($sformatf("din_inst%0d", k), din_of(k), exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // Core model for the 8-bit instance: presents the next queued word after each ack.
  initial begin
    forever begin
      @(negedge CLK);
      if (ack[0] && dout8_next.size() > 0) begin
        @(posedge CLK);
        #1 dout8 = dout8_next.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic xfer(input int k, input int width, input bit cpol, input bit cpha,
                      input bit msb, input int nbits, input logic [31:0] tx,
                      output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb ? width - 1 - i : i;
      if (!cpha) begin
        mosi = tx[b];
        #(HALF); sck[k] = ~cpol; rx[b] = miso[k];
        #(HALF); sck[k] = cpol;
      end else begin
        #(HALF); sck[k] = ~cpol; mosi = tx[b];
        #(HALF); sck[k] = cpol;  rx[b] = miso[k];
      end
    end
  endtask

  task automatic cs_down(input int k);
    cs[k] = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_up(input int k);
    #(2 * HALF);
    cs[k] = 1'b1;
    #(4 * HALF);
  endtask

  initial begin
    logic [31:0] rx;
    int a0, v0, b0;

    cs = '1; sck = 5'b11000; mosi = 1'b0;
    dout8 = 8'h3C; dout16 = 16'hBEEF; RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_miso", miso, 0);  check("rst_ack", ack, 0);   check("rst_valid", vld, 0);
    check("rst_busy", busy, 0);  check("rst_abort", abrt, 0); check("rst_din", din8, 0);
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK); #2;

    // Mode 0, 8-bit LSB-first single word.
    a0 = ack_cnt[0]; v0 = vld_cnt[0];
    exp_q[0].push_back(32'hA5);
    cs_down(0);
    check("t1_ack_at_cs_fall", ack_cnt[0] - a0, 1);
    check("t1_busy", busy[0], 1);
    xfer(0, 8, 0, 0, 0, 8, 32'hA5, rx);
    cs_up(0);
    check("t1_miso_word", rx, 32'h3C);
    check("t1_acks", ack_cnt[0] - a0, 1);
    check("t1_valids", vld_cnt[0] - v0, 1);
    check("t1_din_held", din8, 8'hA5);
    check("t1_busy_off", busy[0], 0);

    // Abort after 5 of 8 bits, then a clean frame.
    a0 = ack_cnt[0]; v0 = vld_cnt[0]; b0 = abt_cnt[0];
    cs_down(0);
    xfer(0, 8, 0, 0, 0, 5, 32'hFF, rx);
    cs_up(0);
    check("t4_abort", abt_cnt[0] - b0, 1);
    check("t4_no_valid", vld_cnt[0] - v0, 0);
    check("t4_din_kept", din8, 8'hA5);
    exp_q[0].push_back(32'h5A);
    cs_down(0);
    xfer(0, 8, 0, 0, 0, 8, 32'h5A, rx);
    cs_up(0);
    check("t4_miso_word", rx, 32'h3C);
    check("t4_valids", vld_cnt[0] - v0, 1);
    check("t4_acks", ack_cnt[0] - a0, 2);
    check("t4_abort_once", abt_cnt[0] - b0, 1);

    // All four modes, 16-bit MSB-first.
    for (int m = 0; m < 4; m++) begin
      int k;
      k = m + 1;
      a0 = ack_cnt[k]; v0 = vld_cnt[k];
      exp_q[k].push_back(32'h1234);
      cs_down(k);
      xfer(k, 16, m[1], m[0], 1, 16, 32'h1234, rx);
      cs_up(k);
      check($sformatf("t2_mode%0d_miso", m), rx, 32'hBEEF);
      check($sformatf("t2_mode%0d_acks", m), ack_cnt[k] - a0, 1);
      check($sformatf("t2_mode%0d_valids", m), vld_cnt[k] - v0, 1);
      check($sformatf("t2_mode%0d_queue", m), exp_q[k].size(), 0);
    end

    // Back-to-back words in one frame, core refreshes DOUT after each ack.
    a0 = ack_cnt[0]; v0 = vld_cnt[0];
    dout8 = 8'h11;
    dout8_next.push_back(8'h22);
    dout8_next.push_back(8'h33);
    cs_down(0);
    for (int w = 1; w <= 3; w++) begin
      exp_q[0].push_back(32'(w));
      xfer(0, 8, 0, 0, 0, 8, 32'(w), rx);
      check($sformatf("t3_miso_word%0d", w), rx, 32'(w * 8'h11));
    end
    cs_up(0);
    check("t3_acks", ack_cnt[0] - a0, 3);
    check("t3_valids", vld_cnt[0] - v0, 3);
    check("t3_queue", exp_q[0].size(), 0);

    // Reset in the middle of a word.
    dout8 = 8'h96;
    cs_down(0);
    xfer(0, 8, 0, 0, 0, 3, 32'hC3, rx);
    RST_N = 1'b0;
    #1;
    check("t5_miso", miso, 0);  check("t5_ack", ack, 0);     check("t5_valid", vld, 0);
    check("t5_busy", busy, 0);  check("t5_abort", abrt, 0);  check("t5_din8", din8, 0);
    check("t5_din16", din_of(1), 0);
    cs[0] = 1'b1;
    #(2 * HALF);
    RST_N = 1'b1;
    #(4 * HALF);
    @(negedge CLK); #2;
    v0 = vld_cnt[0];
    exp_q[0].push_back(32'hC3);
    cs_down(0);
    xfer(0, 8, 0, 0, 0, 8, 32'hC3, rx);
    cs_up(0);
    check("t5_miso_word", rx, 32'h96);
    check("t5_valids", vld_cnt[0] - v0, 1);
    check("t5_din", din8, 8'hC3);

    // SCK activity while deselected.
    a0 = ack_cnt[0]; v0 = vld_cnt[0]; b0 = abt_cnt[0];
    for (int t = 0; t < 16; t++) begin
      sck[0] = ~sck[0];
      mosi   = ~mosi;
      #(HALF);
      check("t6_miso", miso[0], 0);
      check("t6_busy", busy[0], 0);
    end
    #(2 * HALF);
    check("t6_acks", ack_cnt[0] - a0, 0);
    check("t6_valids", vld_cnt[0] - v0, 0);
    check("t6_aborts", abt_cnt[0] - b0, 0);
    for (int k = 0; k < N; k++) check($sformatf("final_queue%0d", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
